uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
Serial front end for the CPU programming port. It receives an 8N1 UART stream on one pin and frames it into a program image: one sync byte, then PROG_BYTES data bytes, then one checksum byte. It drives the programming/new_byte/data handshake that the CPU programming interface consumes, replacing manual toggling of uio_in[1:0] and ui_in. On completion or fault it releases programming so the CPU control block regains the bus.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; must be even and at least 4.
PROG_BYTES, 16, data bytes per image; equals the RAM size.
SYNC_BYTE, 8'hA5, byte that starts a frame.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
rx  input  1  UART receive line, idles high, asynchronous to clk
prog_data  output  8  current program byte; drives ui_in of the CPU
programming  output  1  high while an image is being loaded; drives uio_in[0]
new_byte  output  1  strobe marking prog_data valid; drives uio_in[1]
byte_count  output  5  number of data bytes delivered in the current frame
done  output  1  sticky: last frame loaded with a good checksum
error  output  1  sticky: last frame aborted (framing or checksum fault)

Behaviour:
- Reset (rst high at a clk edge): every output is 0. rx synchroniser flops are set to 1. RX state is IDLE. Frame state is WAIT_SYNC. Checksum is 0.
- rx passes through a 2-flop synchroniser. All logic below uses the synchronised value (rxs).
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge of rxs moves to START and clears the bit timer.
  - START: after CLKS_PER_BIT/2 cycles, sample rxs. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no byte.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. rxs=1 raises an internal byte_valid for one cycle. rxs=0 raises frame_err for one cycle. Either way, return to IDLE the same cycle.
- Frame FSM states: WAIT_SYNC, LOAD, CHECK.
  - WAIT_SYNC: byte_valid with SYNC_BYTE moves to LOAD. On that edge: programming=1, done=0, error=0, byte_count=0, checksum=0. Any other byte and any frame_err are ignored.
  - LOAD: on byte_valid:
    - prog_data takes the byte.
    - checksum = (checksum + byte) mod 256.
    - byte_count increments.
    - new_byte goes high on the cycle after byte_valid and is held for exactly 2 cycles; prog_data is stable for that whole window.
    - When byte_count reaches PROG_BYTES, move to CHECK.
  - CHECK: on byte_valid:
    - If the byte equals checksum: done=1.
    - Otherwise: error=1.
    - Either way, programming=0 the cycle after byte_valid, then go to WAIT_SYNC.
  - Abort: frame_err in LOAD or CHECK sets error=1 and programming=0 on the next cycle, then goes to WAIT_SYNC. byte_count holds its value for diagnosis.
- A SYNC_BYTE value received inside LOAD is ordinary data.
- programming never drops while new_byte is high. Because of UART byte spacing, a new byte_valid can never overlap a new_byte pulse.
- done and error are mutually exclusive. Both hold until the next SYNC_BYTE or rst.
- Reset mid-frame: all state and outputs clear on that edge, including programming=0 and new_byte=0. The partial image is abandoned. The first byte after reset must be a sync byte.
- byte_count saturates at PROG_BYTES and never wraps.

Test Plan:
- Clean load: send A5, bytes 0x01..0x10, checksum 0x88 → 16 new_byte pulses, each 2 cycles wide, with prog_data 0x01..0x10 in order. byte_count reaches 16. programming falls one cycle after the checksum stop sample. done=1, error=0.
- Bad checksum: same frame with checksum 0x89 → all 16 pulses delivered, then error=1, done=0, programming=0.
- Framing error: stop bit of data byte 5 forced low → no 5th pulse, error=1, byte_count=4, programming=0. A following A5 clears error and restarts with byte_count=0.
- Garbage before sync: send 0x00, 0xFF, 0x3C, then a valid frame → no pulses and programming=0 until A5 arrives; then a normal load.
- Glitch: rx low for CLKS_PER_BIT/4 cycles while idle → no byte, no state change. rst asserted during byte 8 → all outputs 0 the next cycle. Data bytes without a new A5 are ignored.

Source files
------------

// File: rtl/uart_program_loader.sv
// UART 8N1 receiver that frames sync + image + checksum into the
// programming/new_byte/prog_data handshake of the CPU programming port.
module uart_program_loader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          PROG_BYTES   = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] prog_data,
  output logic       programming,
  output logic       new_byte,
  output logic [4:0] byte_count,
  output logic       done,
  output logic       error
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    PB   = 5'(PROG_BYTES);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  typedef enum logic [1:0] {
    F_WAIT, F_LOAD, F_CHECK
  } fr_st_t;

  logic          meta_q, rxs_q, rxs_prev_q;
  rx_st_t        rx_st_q, rx_st_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid, frame_err;

  fr_st_t        fr_st_q, fr_st_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    sum_q, sum_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          prog_q, prog_d;
  logic          nb_q, nb_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      rx_st_q    <= RX_IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      fr_st_q    <= F_WAIT;
      data_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      prog_q     <= 1'b0;
      nb_q       <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      meta_q     <= rx;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
      rx_st_q    <= rx_st_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      fr_st_q    <= fr_st_d;
      data_q     <= data_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      prog_q     <= prog_d;
      nb_q       <= nb_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Bit-level receiver; byte_valid/frame_err pulse on the stop sample.
  always_comb begin
    rx_st_d    = rx_st_q;
    timer_d    = timer_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          rx_st_d = RX_START;
          timer_d = '0;
        end
      end
      RX_START: begin
        if (timer_q == HALF) begin
          timer_d = '0;
          bit_d   = '0;
          rx_st_d = rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (timer_q == FULL) begin
          timer_d = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (timer_q == FULL) begin
          timer_d    = '0;
          rx_st_d    = RX_IDLE;
          byte_valid = rxs_q;
          frame_err  = !rxs_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Frame-level sequencing: sync, PROG_BYTES data bytes, checksum.
  always_comb begin
    fr_st_d = fr_st_q;
    data_d  = data_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    prog_d  = prog_q;
    done_d  = done_q;
    err_d   = err_q;
    nb_d    = hold_q;
    hold_d  = 1'b0;
    unique case (fr_st_q)
      F_WAIT: begin
        if (byte_valid && shift_q == SYNC_BYTE) begin
          fr_st_d = F_LOAD;
          prog_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      F_LOAD: begin
        if (byte_valid) begin
          data_d = shift_q;
          sum_d  = sum_q + shift_q;
          nb_d   = 1'b1;
          hold_d = 1'b1;
          if (cnt_q < PB) cnt_d = cnt_q + 5'd1;
          if (cnt_q == PB - 5'd1) fr_st_d = F_CHECK;
        end else if (frame_err) begin
          err_d   = 1'b1;
          prog_d  = 1'b0;
          fr_st_d = F_WAIT;
        end
      end
      F_CHECK: begin
        if (byte_valid) begin
          done_d  = (shift_q == sum_q);
          err_d   = (shift_q != sum_q);
          prog_d  = 1'b0;
          fr_st_d = F_WAIT;
        end else if (frame_err) begin
          err_d   = 1'b1;
          prog_d  = 1'b0;
          fr_st_d = F_WAIT;
        end
      end
      default: fr_st_d = F_WAIT;
    endcase
  end

  assign prog_data   = data_q;
  assign programming = prog_q;
  assign new_byte    = nb_q;
  assign byte_count  = cnt_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a pulse-level scoreboard.
module tb_uart_program_loader;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] prog_data;
  logic       programming;
  logic       new_byte;
  logic [4:0] byte_count;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .PROG_BYTES(16),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .prog_data(prog_data),
    .programming(programming),
    .new_byte(new_byte),
    .byte_count(byte_count),
    .done(done),
    .error(error)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_mem [256];
  int wr_idx = 0;
  int rd_idx = 0;
  int pulses = 0;
  int base   = 0;
  int nb_run = 0;
  logic [7:0] cur = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        nb_run = 0;
      end else begin
        chk("done_error_exclusive", int'(done && error), 0);
        if (new_byte) begin
          if (nb_run == 0) begin
            chk("pulse_expected", int'(wr_idx > rd_idx), 1);
            if (wr_idx > rd_idx) begin
              chk("prog_data", prog_data, exp_mem[rd_idx[7:0]]);
              rd_idx++;
            end
            pulses++;
            chk("byte_count_at_pulse", byte_count, pulses - base);
            cur = prog_data;
          end else begin
            chk("prog_data_stable", prog_data, cur);
          end
          chk("programming_during_new_byte", programming, 1);
          nb_run++;
        end else if (nb_run > 0) begin
          chk("new_byte_width", nb_run, 2);
          nb_run = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_mem[wr_idx[7:0]] = b;
    wr_idx++;
  endtask

  task automatic send_sync();
    send_byte(8'hA5, 1'b1);
    base = pulses;
  endtask

  task automatic send_frame(input logic [7:0] d [16], input logic [7:0] ck);
    send_sync();
    for (int i = 0; i < 16; i++) begin
      expect_byte(d[i]);
      send_byte(d[i], 1'b1);
    end
    send_byte(ck, 1'b1);
  endtask

  task automatic check_end(input string tag, input int e_done, input int e_err,
                           input int e_cnt);
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_error"}, error, e_err);
    chk({tag, "_programming"}, programming, 0);
    chk({tag, "_byte_count"}, byte_count, e_cnt);
    chk({tag, "_all_delivered"}, rd_idx, wr_idx);
  endtask

  task automatic main();
    logic [7:0] d [16];
    logic [7:0] sum;

    idle(3);
    chk("rst_prog_data", prog_data, 0);
    chk("rst_programming", programming, 0);
    chk("rst_new_byte", new_byte, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    idle(2 * CPB);

    for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
    send_frame(d, 8'h88);
    check_end("clean", 1, 0, 16);
    chk("clean_last_data", prog_data, 8'h10);

    send_frame(d, 8'h89);
    check_end("badsum", 0, 1, 16);

    send_sync();
    chk("frm_sync_programming", programming, 1);
    for (int i = 1; i <= 4; i++) begin
      expect_byte(8'(i));
      send_byte(8'(i), 1'b1);
    end
    send_byte(8'h05, 1'b0);
    check_end("framing", 0, 1, 4);
    send_sync();
    chk("resync_error", error, 0);
    chk("resync_byte_count", byte_count, 0);
    chk("resync_programming", programming, 1);
    for (int i = 0; i < 16; i++) begin
      expect_byte(d[i]);
      send_byte(d[i], 1'b1);
    end
    send_byte(8'h88, 1'b1);
    check_end("reload", 1, 0, 16);

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    chk("garbage_programming", programming, 0);
    chk("garbage_done_held", done, 1);
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      d[i] = 8'(i * 37 + 5);
      if (i == 3) d[i] = 8'hA5;
      sum = sum + d[i];
    end
    send_frame(d, sum);
    check_end("garbage_then_frame", 1, 0, 16);

    rx = 1'b0;
    idle(CPB / 4);
    rx = 1'b1;
    idle(4 * CPB);
    chk("glitch_programming", programming, 0);
    chk("glitch_done", done, 1);
    chk("glitch_byte_count", byte_count, 16);
    send_byte(8'h77, 1'b1);
    chk("stray_byte_done", done, 1);

    send_sync();
    for (int i = 0; i < 7; i++) begin
      expect_byte(8'(i + 8'h40));
      send_byte(8'(i + 8'h40), 1'b1);
    end
    chk("pre_rst_count", byte_count, 7);
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(3 * CPB);
    rst = 1'b1;
    idle(1);
    chk("midrst_prog_data", prog_data, 0);
    chk("midrst_programming", programming, 0);
    chk("midrst_new_byte", new_byte, 0);
    chk("midrst_byte_count", byte_count, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    idle(1);
    rst = 1'b0;
    base = pulses;
    idle(2 * CPB);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("nosync_programming", programming, 0);
    chk("nosync_byte_count", byte_count, 0);
    chk("nosync_done", done, 0);
    chk("nosync_delivered", rd_idx, wr_idx);
  endtask

  initial begin
    fork
      monitor();
      main();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
